calc_bcd_seq: RTL and testbench
===============================

CALC_BCD_SEQ -- requirements
Module: calc_bcd_seq

Interface
REQ-001 The block SHALL have parameter NDIG, default 8, legal range 2..8, meaning the number of BCD digits held and displayed.
REQ-002 The block SHALL derive local parameter POSW = max(1, clog2(NDIG)), meaning the width of the digit-position output.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: cmd is sampled on each cycle where this is 1.
REQ-006 The block SHALL have port cmd, input, 4 bits: 0-9 digit, A ADD, B SUB, C reserved, D BACKSPACE, E EQUALS, F CLEAR.
REQ-007 The block SHALL have port status, output, 2 bits: 00 READY, 01 OP_PENDING, 10 BUSY, 11 ERR.
REQ-008 The block SHALL have port digits, output, 4*NDIG bits: the packed BCD entry/result register; digit 0 sits in the LSBs.
REQ-009 The block SHALL have port data, output, 4 bits: the BCD digit currently being streamed to the display controller.
REQ-010 The block SHALL have port pos, output, POSW bits: the position of data.
REQ-011 The block SHALL have port data_valid, output, 1 bit: data and pos are valid on cycles where this is 1.
REQ-012 The block SHALL have port neg, output, 1 bit: the result is negative.

Function
REQ-013 A digit command SHALL shift digits left by one digit and insert cmd at digit 0. It is ignored when digit NDIG-1 is nonzero.
REQ-014 BACKSPACE SHALL shift digits right by one digit, fill the MSD with 0, and clear neg.
REQ-015 ADD/SUB in READY SHALL copy digits to internal operand A, latch the op, clear digits, and set status to 01.
REQ-016 ADD/SUB in OP_PENDING SHALL replace the latched op only; digits are unchanged.
REQ-017 EQUALS in OP_PENDING SHALL enter BUSY on the next cycle and run a digit-serial BCD pass, LSD first, one digit per cycle, NDIG cycles. EQUALS in READY is ignored.
REQ-018 ADD SHALL compute A + digits. A carry out of the MSD is overflow: status goes to 11 and digits is cleared.
REQ-019 SUB SHALL compute A - digits. A final borrow is handled per REQ-027/REQ-028.
REQ-020 When a pass completes without error, the result SHALL be written to digits, status SHALL return to 00, and the op SHALL be cleared.
REQ-021 In BUSY, every command except CLEAR SHALL be dropped and not queued.
REQ-022 CLEAR in any state SHALL abort any pass and, on the next cycle, set digits=0, A=0, neg=0, status=00, and the op to none.
REQ-023 In ERR, all commands except CLEAR SHALL be ignored. Reserved cmd C SHALL be ignored in all states.
REQ-024 Any change to digits SHALL start a display scan on the next cycle.
  - Scan length: NDIG consecutive cycles with data_valid=1.
  - pos counts NDIG-1 down to 0; data equals the digit at pos.
REQ-025 If digits changes mid-scan, the scan SHALL restart at pos=NDIG-1 on the next cycle. No scan runs while BUSY.
REQ-026 When data_valid=0, data and pos SHALL hold 0.

Configuration
REQ-027 With macro CALC_NEG_EN defined, a SUB final borrow SHALL trigger a second NDIG-cycle pass computing 0 minus the intermediate result.
  - The magnitude goes to digits and neg is set to 1.
  - BUSY lasts 2*NDIG cycles.
REQ-028 Without CALC_NEG_EN, a SUB final borrow SHALL set status 11 and clear digits. neg SHALL be tied to 0.

Reset
REQ-029 Asserting reset SHALL immediately force all outputs to their reset values.
  - status=00, digits=0, data=0, pos=0, data_valid=0, neg=0.
  - A=0, op none, scan idle.
REQ-030 Reset asserted mid-pass or mid-scan SHALL discard that pass or scan with no partial result.
REQ-031 After reset deasserts, the block SHALL start one display scan on the first clock edge.

Verification (NDIG=8)
REQ-032 Enter 1,2,3 -> digits=0x00000123, status=00, and 8 valid cycles with pos 7..0 and data 0,0,0,0,0,1,2,3.
REQ-033 Enter 1,2, ADD, 3,4, EQUALS -> status=10 for exactly 8 cycles, then digits=0x00000046, status=00, and a scan restarts.
REQ-034 Enter 9 eight times, ADD, 1, EQUALS -> status=11 and digits=0; a following 5 is ignored; CLEAR -> status=00.
REQ-035 Enter 5, SUB, 7, EQUALS:
  - With CALC_NEG_EN: 16 BUSY cycles, then digits=0x00000002 and neg=1.
  - Without CALC_NEG_EN: status=11 and digits=0.
REQ-036 Command 3 issued during BUSY -> dropped, result unaffected. CLEAR at BUSY cycle 4 -> next cycle status=00 and digits=0.
REQ-037 Reset asserted at scan pos=4 -> data_valid=0 before the next edge. After release, exactly one fresh 8-cycle scan of zeros.

Source files
------------

// File: rtl/calc_bcd_seq.sv
// calc_bcd_seq : BCD entry calculator with a digit-serial add/subtract engine
//                and a display scan streamer.
//
// Optional feature: define CALC_NEG_EN to resolve a subtraction borrow with a
// second pass (0 - intermediate) and report the sign on neg. Without it a
// borrow is an error and neg stays 0.
//
// Ports
//   clock       single clock, rising edge
//   reset       asynchronous, active-high
//   cmd_valid   cmd is sampled when 1
//   cmd         0-9 digit, A add, B sub, C reserved, D backspace, E equals, F clear
//   status      00 ready, 01 op pending, 10 busy, 11 error
//   digits      packed BCD entry/result register, digit 0 in the LSBs
//   data/pos    digit being streamed to the display and its position
//   data_valid  data/pos qualifier (both forced to 0 when low)
//   neg         result is negative
//
// state    | meaning
// S_READY  | entering the first operand (or showing a result)
// S_OPPEND | operator latched, entering the second operand
// S_PASS1  | digit-serial A op B, LSD first, NDIG cycles
// S_PASS2  | 0 - intermediate after a subtraction borrow (CALC_NEG_EN only)
// S_ERR    | overflow/borrow error, waits for clear
module calc_bcd_seq #(
    parameter int NDIG = 8,
    localparam int POSW = ($clog2(NDIG) > 1) ? $clog2(NDIG) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd,
    output logic [1:0]        status,
    output logic [4*NDIG-1:0] digits,
    output logic [3:0]        data,
    output logic [POSW-1:0]   pos,
    output logic              data_valid,
    output logic              neg
);
    localparam int              DW   = 4*NDIG;
    localparam logic [POSW-1:0] LAST = POSW'(NDIG-1);

    localparam logic [3:0] CMD_ADD = 4'hA;
    localparam logic [3:0] CMD_SUB = 4'hB;
    localparam logic [3:0] CMD_BSP = 4'hD;
    localparam logic [3:0] CMD_EQ  = 4'hE;
    localparam logic [3:0] CMD_CLR = 4'hF;

    typedef enum logic [2:0] {S_READY, S_OPPEND, S_PASS1, S_PASS2, S_ERR} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB} op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [DW-1:0]   digits_q, digits_d, a_q, a_d;
    logic [DW-1:0]   opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic            cy_q, cy_d, neg_q, neg_d;
    logic [POSW-1:0] cnt_q, cnt_d, spos_q, spos_d;
    logic            scan_q, scan_d, boot_q;
    logic            pass_done;
    logic            sub_mode, cy_out;
    logic [4:0]      sum;
    logic [3:0]      rdig;

    // One BCD digit of the pass: operands are consumed from the bottom of
    // the opa/opb shift registers, cy_q is carry (add) or borrow (sub).
    always_comb begin
        sub_mode = (state_q == S_PASS2) || (op_q == OP_SUB);
        cy_out   = 1'b0;
        if (sub_mode) begin
            sum = {1'b0, opa_q[3:0]} - {1'b0, opb_q[3:0]} - {4'd0, cy_q};
            if (sum[4]) begin
                sum    = sum + 5'd10;
                cy_out = 1'b1;
            end
        end else begin
            sum = {1'b0, opa_q[3:0]} + {1'b0, opb_q[3:0]} + {4'd0, cy_q};
            if (sum > 5'd9) begin
                sum    = sum - 5'd10;
                cy_out = 1'b1;
            end
        end
        rdig = sum[3:0];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        digits_d  = digits_q;
        a_d       = a_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        cy_d      = cy_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        pass_done = 1'b0;
        if (cmd_valid && cmd == CMD_CLR) begin
            state_d  = S_READY;
            op_d     = OP_NONE;
            digits_d = '0;
            a_d      = '0;
            neg_d    = 1'b0;
        end else begin
            case (state_q)
                S_READY, S_OPPEND: begin
                    if (cmd_valid) begin
                        if (cmd <= 4'd9) begin
                            if (digits_q[DW-1 -: 4] == 4'd0)
                                digits_d = {digits_q[DW-5:0], cmd};
                        end else if (cmd == CMD_BSP) begin
                            digits_d = {4'd0, digits_q[DW-1:4]};
                            neg_d    = 1'b0;
                        end else if (cmd == CMD_ADD || cmd == CMD_SUB) begin
                            op_d = (cmd == CMD_ADD) ? OP_ADD : OP_SUB;
                            if (state_q == S_READY) begin
                                a_d      = digits_q;
                                digits_d = '0;
                                state_d  = S_OPPEND;
                            end
                        end else if (cmd == CMD_EQ && state_q == S_OPPEND) begin
                            state_d = S_PASS1;
                            opa_d   = a_q;
                            opb_d   = digits_q;
                            cy_d    = 1'b0;
                            cnt_d   = LAST;
                        end
                    end
                end
                S_PASS1, S_PASS2: begin
                    opa_d = {4'd0, opa_q[DW-1:4]};
                    opb_d = {4'd0, opb_q[DW-1:4]};
                    res_d = {rdig, res_q[DW-1:4]};
                    cy_d  = cy_out;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        pass_done = 1'b1;
                        state_d   = S_READY;
                        op_d      = OP_NONE;
                        digits_d  = res_d;
                        neg_d     = (state_q == S_PASS2);
                        if (cy_out && state_q == S_PASS1) begin
                            if (op_q == OP_ADD) begin
                                state_d  = S_ERR;
                                digits_d = '0;
                                neg_d    = 1'b0;
                            end else begin
`ifdef CALC_NEG_EN
                                // Borrow: intermediate is 10^NDIG - |A-B|,
                                // so 0 - intermediate yields the magnitude.
                                pass_done = 1'b0;
                                state_d   = S_PASS2;
                                op_d      = op_q;
                                digits_d  = digits_q;
                                neg_d     = neg_q;
                                opa_d     = '0;
                                opb_d     = res_d;
                                cy_d      = 1'b0;
                                cnt_d     = LAST;
`else
                                state_d  = S_ERR;
                                digits_d = '0;
                                neg_d    = 1'b0;
`endif
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        // A finished pass always rescans, even if the value is unchanged.
        scan_d = scan_q;
        spos_d = spos_q;
        if (state_d == S_PASS1 || state_d == S_PASS2) begin
            scan_d = 1'b0;
        end else if (boot_q || pass_done || digits_d != digits_q) begin
            scan_d = 1'b1;
            spos_d = LAST;
        end else if (scan_q) begin
            if (spos_q == '0) scan_d = 1'b0;
            else              spos_d = spos_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_READY;
            op_q     <= OP_NONE;
            digits_q <= '0;
            a_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            scan_q   <= 1'b0;
            spos_q   <= '0;
            boot_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            digits_q <= digits_d;
            a_q      <= a_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            scan_q   <= scan_d;
            spos_q   <= spos_d;
            boot_q   <= 1'b0;
        end
    end

    always_comb begin
        case (state_q)
            S_OPPEND:         status = 2'b01;
            S_PASS1, S_PASS2: status = 2'b10;
            S_ERR:            status = 2'b11;
            default:          status = 2'b00;
        endcase
    end

    assign digits     = digits_q;
    assign neg        = neg_q;
    assign data_valid = scan_q;
    assign pos        = scan_q ? spos_q : '0;
    assign data       = scan_q ? digits_q[4*int'(spos_q) +: 4] : 4'd0;

endmodule

// File: tb/tb_calc_bcd_seq.sv
module tb_calc_bcd_seq;
    localparam int    NDIG = 8;
    localparam longint LIM = 100000000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd = 4'd0;
    logic [1:0]  status;
    logic [31:0] digits;
    logic [3:0]  data;
    logic [2:0]  pos;
    logic        data_valid;
    logic        neg;

    calc_bcd_seq #(.NDIG(NDIG)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .status(status), .digits(digits), .data(data), .pos(pos),
        .data_valid(data_valid), .neg(neg)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: operands held as plain integers.
    int     m_state;        // 0 ready, 1 op pending, 2 busy, 3 error
    longint m_val, m_a, m_res;
    int     m_op;           // 0 none, 1 add, 2 sub
    bit     m_neg, m_res_neg, m_res_err;
    int     m_busy;
    bit     m_scan, m_boot;
    int     m_spos;

    typedef struct {
        bit          v;
        logic [3:0]  c;
        logic [1:0]  st;
        logic [31:0] dg;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] to_bcd(input longint v);
        logic [31:0] r;
        longint      t;
        r = '0;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int dig_at(input longint v, input int p);
        longint t;
        t = v;
        for (int i = 0; i < p; i++) t = t / 10;
        return int'(t % 10);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_val = 0; m_a = 0; m_res = 0; m_op = 0;
        m_neg = 0; m_res_neg = 0; m_res_err = 0; m_busy = 0;
        m_scan = 0; m_spos = 0; m_boot = 1;
    endtask

    task automatic model_step(input bit v, input logic [3:0] c);
        longint old;
        bit     done;
        old  = m_val;
        done = 0;
        if (v && c == 4'hF) begin
            m_state = 0; m_val = 0; m_a = 0; m_neg = 0; m_op = 0; m_busy = 0;
        end else begin
            case (m_state)
                0, 1: if (v) begin
                    if (c <= 4'd9) begin
                        if (m_val < LIM / 10) m_val = m_val * 10 + longint'(c);
                    end else if (c == 4'hD) begin
                        m_val = m_val / 10;
                        m_neg = 0;
                    end else if (c == 4'hA || c == 4'hB) begin
                        if (m_state == 0) begin
                            m_a = m_val; m_val = 0; m_state = 1;
                        end
                        m_op = (c == 4'hA) ? 1 : 2;
                    end else if (c == 4'hE && m_state == 1) begin
                        m_res_neg = 0; m_res_err = 0; m_busy = NDIG;
                        if (m_op == 1) begin
                            m_res = m_a + m_val;
                            m_res_err = (m_res >= LIM);
                        end else begin
                            m_res = m_a - m_val;
                            if (m_res < 0) begin
`ifdef CALC_NEG_EN
                                m_res = -m_res; m_res_neg = 1; m_busy = 2 * NDIG;
`else
                                m_res_err = 1;
`endif
                            end
                        end
                        m_state = 2;
                    end
                end
                2: begin
                    m_busy--;
                    if (m_busy == 0) begin
                        done = 1; m_op = 0;
                        if (m_res_err) begin
                            m_state = 3; m_val = 0; m_neg = 0;
                        end else begin
                            m_state = 0; m_val = m_res; m_neg = m_res_neg;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (m_state == 2) begin
            m_scan = 0;
        end else if (m_boot || done || m_val != old) begin
            m_scan = 1; m_spos = NDIG - 1;
        end else if (m_scan) begin
            if (m_spos == 0) m_scan = 0;
            else             m_spos--;
        end
        m_boot = 0;
    endtask

    task automatic check_model();
        chk("status", 64'(status), 64'(m_state));
        chk("digits", 64'(digits), 64'(to_bcd(m_val)));
        chk("neg", 64'(neg), 64'(m_neg));
        chk("data_valid", 64'(data_valid), 64'(m_scan));
        chk("pos", 64'(pos), m_scan ? 64'(m_spos) : 64'd0);
        chk("data", 64'(data), m_scan ? 64'(dig_at(m_val, m_spos)) : 64'd0);
    endtask

    task automatic tick(input bit v, input logic [3:0] c);
        cmd_valid = v;
        cmd       = c;
        @(posedge clock);
        model_step(v, c);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_digits", 64'(digits), 64'd0);
        chk("rst_dv", 64'(data_valid), 64'd0);
        chk("rst_pos", 64'(pos), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_neg", 64'(neg), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (status != 2'b10) break;
            n++;
            tick(0, 4'd0);
        end
    endtask

    task automatic push(input bit v, input logic [3:0] c, input logic [1:0] st,
                        input logic [31:0] dg, input int times);
        for (int i = 0; i < times; i++) tbl.push_back('{v, c, st, dg});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int found;
        int cnt_v;
        int nz;
        int exp_d[8];
        exp_d = '{0, 0, 0, 0, 0, 1, 2, 3};

        model_reset();
        #1;
        chk("init_status", 64'(status), 64'd0);
        chk("init_digits", 64'(digits), 64'd0);
        chk("init_dv", 64'(data_valid), 64'd0);
        chk("init_pos", 64'(pos), 64'd0);
        chk("init_data", 64'(data), 64'd0);
        chk("init_neg", 64'(neg), 64'd0);
        #11;
        reset = 1'b0;

        // Table: entry, edit, reserved, op replace, subtraction, equals in ready.
        push(1, 4'hF, 2'b00, 32'h0, 1);
        push(1, 4'h1, 2'b00, 32'h1, 1);
        push(1, 4'h2, 2'b00, 32'h12, 1);
        push(1, 4'h3, 2'b00, 32'h123, 1);
        push(1, 4'hD, 2'b00, 32'h12, 1);
        push(1, 4'hC, 2'b00, 32'h12, 1);
        push(0, 4'h7, 2'b00, 32'h12, 1);
        push(1, 4'h4, 2'b00, 32'h124, 1);
        push(1, 4'hA, 2'b01, 32'h0, 1);
        push(1, 4'h5, 2'b01, 32'h5, 1);
        push(1, 4'hB, 2'b01, 32'h5, 1);
        push(1, 4'hE, 2'b10, 32'h5, 1);
        push(0, 4'h0, 2'b10, 32'h5, 7);
        push(0, 4'h0, 2'b00, 32'h119, 1);
        push(1, 4'hE, 2'b00, 32'h119, 1);
        push(1, 4'hA, 2'b01, 32'h0, 1);
        push(1, 4'h1, 2'b01, 32'h1, 1);
        push(1, 4'hE, 2'b10, 32'h1, 1);
        push(0, 4'h0, 2'b10, 32'h1, 7);
        push(0, 4'h0, 2'b00, 32'h120, 1);
        push(1, 4'hF, 2'b00, 32'h0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].v, tbl[i].c);
            chk($sformatf("tbl%0d_status", i), 64'(status), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_digits", i), 64'(digits), 64'(tbl[i].dg));
        end

        // Entry 1,2,3 and the scan that follows.
        tick(1, 4'h1); tick(1, 4'h2); tick(1, 4'h3);
        chk("e123_digits", 64'(digits), 64'h123);
        chk("e123_status", 64'(status), 64'd0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("e123_dv%0d", k), 64'(data_valid), 64'd1);
            chk($sformatf("e123_pos%0d", k), 64'(pos), 64'(7 - k));
            chk($sformatf("e123_data%0d", k), 64'(data), 64'(exp_d[k]));
            tick(0, 4'd0);
        end
        chk("e123_scan_end", 64'(data_valid), 64'd0);

        // 12 + 34.
        tick(1, 4'hF); tick(1, 4'h1); tick(1, 4'h2); tick(1, 4'hA);
        tick(1, 4'h3); tick(1, 4'h4); tick(1, 4'hE);
        run_busy(n);
        chk("add_busy_len", 64'(n), 64'd8);
        chk("add_digits", 64'(digits), 64'h46);
        chk("add_status", 64'(status), 64'd0);
        chk("add_rescan", 64'(data_valid && pos == 3'd7), 64'd1);

        // Overflow.
        tick(1, 4'hF);
        for (int i = 0; i < 8; i++) tick(1, 4'h9);
        chk("ovf_entry", 64'(digits), 64'h99999999);
        tick(1, 4'h9);
        chk("ovf_full_ignored", 64'(digits), 64'h99999999);
        tick(1, 4'hA); tick(1, 4'h1); tick(1, 4'hE);
        run_busy(n);
        chk("ovf_status", 64'(status), 64'd3);
        chk("ovf_digits", 64'(digits), 64'd0);
        tick(1, 4'h5);
        chk("err_ignore_status", 64'(status), 64'd3);
        chk("err_ignore_digits", 64'(digits), 64'd0);
        tick(1, 4'hF);
        chk("err_clear", 64'(status), 64'd0);

        // 5 - 7.
        tick(1, 4'h5); tick(1, 4'hB); tick(1, 4'h7); tick(1, 4'hE);
        run_busy(n);
`ifdef CALC_NEG_EN
        chk("sub_busy_len", 64'(n), 64'd16);
        chk("sub_digits", 64'(digits), 64'h2);
        chk("sub_neg", 64'(neg), 64'd1);
        chk("sub_status", 64'(status), 64'd0);
        tick(1, 4'hD);
        chk("bsp_clears_neg", 64'(neg), 64'd0);
`else
        chk("sub_busy_len", 64'(n), 64'd8);
        chk("sub_status", 64'(status), 64'd3);
        chk("sub_digits", 64'(digits), 64'd0);
        chk("sub_neg", 64'(neg), 64'd0);
`endif

        // Command during busy is dropped; clear aborts a pass.
        tick(1, 4'hF); tick(1, 4'h1); tick(1, 4'h2); tick(1, 4'hA);
        tick(1, 4'h3); tick(1, 4'h4); tick(1, 4'hE);
        tick(1, 4'h3);
        run_busy(n);
        chk("drop_busy_len", 64'(n), 64'd7);
        chk("drop_digits", 64'(digits), 64'h46);
        tick(1, 4'hF); tick(1, 4'h1); tick(1, 4'hA); tick(1, 4'h2); tick(1, 4'hE);
        tick(0, 4'd0); tick(0, 4'd0); tick(0, 4'd0);
        chk("abort_busy4", 64'(status), 64'd2);
        tick(1, 4'hF);
        chk("abort_status", 64'(status), 64'd0);
        chk("abort_digits", 64'(digits), 64'd0);
        tick(0, 4'd0);
        chk("abort_stays", 64'(digits), 64'd0);

        // Reset in the middle of a scan.
        tick(1, 4'h1); tick(1, 4'h2); tick(1, 4'h3);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (data_valid && pos == 3'd4) begin
                found = 1;
                break;
            end
            tick(0, 4'd0);
        end
        chk("scan_reach_pos4", 64'(found), 64'd1);
        do_reset();
        cnt_v = 0;
        nz = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 4'd0);
            if (data_valid) begin
                cnt_v++;
                if (data != 4'd0) nz++;
            end
        end
        chk("boot_scan_len", 64'(cnt_v), 64'd8);
        chk("boot_scan_zero", 64'(nz), 64'd0);

        // Random commands against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [3:0] c;
            bit v;
            v = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if      (r < 55) c = 4'($urandom_range(0, 9));
            else if (r < 62) c = 4'hA;
            else if (r < 69) c = 4'hB;
            else if (r < 74) c = 4'hC;
            else if (r < 80) c = 4'hD;
            else if (r < 93) c = 4'hE;
            else             c = 4'hF;
            tick(v, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
